// File: rtl/updi_pkg.sv
// -----------------------------------------------------------------------------
// updi_pkg
// Shared UPDI definitions: protocol byte constants and the state type used by
// the response handler FSM.
// -----------------------------------------------------------------------------
package updi_pkg;

    localparam logic [7:0] UPDI_SYNCH = 8'h55;
    localparam logic [7:0] UPDI_ACK   = 8'h40;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FINISH
    } state_t;

endpackage

// File: rtl/updi_timeout_counter.sv
// -----------------------------------------------------------------------------
// updi_timeout_counter
// Idle-cycle counter for the response handler. Counts enabled cycles since the
// last clear and flags expiry once TIMEOUT_CYCLES-1 is reached; it then holds
// until cleared.
// Ports:
//   i_clk      clock
//   i_rst      asynchronous active-high reset
//   i_clear    restart the count from zero (has priority over i_enable)
//   i_enable   count this cycle
//   o_expired  count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module updi_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/updi_response_handler.sv
// -----------------------------------------------------------------------------
// updi_response_handler
// Receive side of the UPDI link. Pops bytes from the UART RX FIFO, drops the
// single-wire echo of transmitted bytes, captures the response payload and
// optionally checks a trailing ACK byte (0x40).
//
// Optional feature: define UPDI_RESPONSE_TIMEOUT_EN to abort a transaction
// after TIMEOUT_CYCLES consecutive READ cycles without a received byte.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               begin a transaction (only while o_ready)
//   o_ready               idle, accepts i_start
//   o_done                1-cycle end-of-transaction pulse
//   o_error               1-cycle pulse with o_done: bad length, ACK mismatch, timeout
//   o_ack_received        1-cycle pulse when the expected ACK byte is 0x40
//   i_discard_len         echo bytes to drop first
//   i_rx_len              response bytes to capture
//   i_expect_ack          read one ACK byte after the payload
//   o_data                captured bytes, o_data[0] received first
//   o_data_count          bytes captured in this transaction
//   i_fifo_data           RX FIFO output, valid the cycle after o_fifo_rd_en
//   o_fifo_rd_en          RX FIFO pop
//   i_fifo_empty          RX FIFO empty
// -----------------------------------------------------------------------------
module updi_response_handler
    import updi_pkg::*;
#(
    parameter int MAX_DATA_SIZE  = 16,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    output logic                           o_ready,
    output logic                           o_done,
    output logic                           o_error,
    output logic                           o_ack_received,
    input  logic [DATA_ADDR_BITS:0]        i_discard_len,
    input  logic [DATA_ADDR_BITS:0]        i_rx_len,
    input  logic                           i_expect_ack,
    output logic [MAX_DATA_SIZE-1:0][7:0]  o_data,
    output logic [DATA_ADDR_BITS:0]        o_data_count,
    input  logic [7:0]                     i_fifo_data,
    output logic                           o_fifo_rd_en,
    input  logic                           i_fifo_empty
);

    localparam int LW = DATA_ADDR_BITS + 1;
    localparam int TW = DATA_ADDR_BITS + 2;

    state_t                        r_state;
    state_t                        w_next;
    logic [LW-1:0]                 r_discard_len;
    logic [LW-1:0]                 r_rx_len;
    logic [LW-1:0]                 r_data_count;
    logic                          r_expect_ack;
    logic                          r_error;
    logic                          r_pending;
    logic [TW-1:0]                 r_total;
    logic [TW-1:0]                 r_issued;
    logic [TW-1:0]                 r_processed;
    logic [MAX_DATA_SIZE-1:0][7:0] r_data;

    logic          w_start;
    logic          w_bad_len;
    logic [TW-1:0] w_start_total;
    logic [TW-1:0] w_data_end;
    logic          w_last;
    logic          w_is_data;
    logic          w_is_ack;
    logic          w_ack_ok;
    logic          w_timeout;

    assign w_start       = (r_state == IDLE) && i_start;
    assign w_bad_len     = (i_rx_len > LW'(MAX_DATA_SIZE));
    assign w_start_total = TW'(i_discard_len) + TW'(i_rx_len) + TW'(i_expect_ack);

    // r_pending marks the byte popped last cycle now present on i_fifo_data;
    // r_processed is its index within the transaction.
    assign w_data_end = TW'(r_discard_len) + TW'(r_rx_len);
    assign w_last     = r_pending && (r_processed == r_total - 1'b1);
    assign w_is_data  = r_pending && (r_processed >= TW'(r_discard_len))
                                  && (r_processed <  w_data_end);
    assign w_is_ack   = w_last && r_expect_ack;
    assign w_ack_ok   = w_is_ack && (i_fifo_data == UPDI_ACK);

`ifdef UPDI_RESPONSE_TIMEOUT_EN
    logic w_expired;

    updi_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_start || r_pending),
        .i_enable  ((r_state == READ) && !r_pending),
        .o_expired (w_expired)
    );

    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_timeout = (r_state == READ) && !r_pending && w_expired;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        o_ready        = 1'b0;
        o_done         = 1'b0;
        o_error        = 1'b0;
        o_ack_received = 1'b0;
        o_fifo_rd_en   = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_next = (w_bad_len || (w_start_total == '0)) ? FINISH : READ;
                end
            end
            READ: begin
                o_fifo_rd_en   = !i_fifo_empty && (r_issued < r_total) && !w_timeout;
                o_ack_received = w_ack_ok;
                if (w_last || w_timeout) begin
                    w_next = FINISH;
                end
            end
            FINISH: begin
                o_done  = 1'b1;
                o_error = r_error;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_discard_len <= '0;
            r_rx_len      <= '0;
            r_expect_ack  <= 1'b0;
            r_total       <= '0;
            r_issued      <= '0;
            r_processed   <= '0;
            r_pending     <= 1'b0;
            r_data_count  <= '0;
            r_error       <= 1'b0;
            r_data        <= '0;
        end else begin
            r_pending <= o_fifo_rd_en;
            if (w_start) begin
                r_discard_len <= i_discard_len;
                r_rx_len      <= i_rx_len;
                r_expect_ack  <= i_expect_ack;
                r_total       <= w_start_total;
                r_issued      <= '0;
                r_processed   <= '0;
                r_data_count  <= '0;
                r_error       <= w_bad_len;
            end
            if (o_fifo_rd_en) begin
                r_issued <= r_issued + 1'b1;
            end
            if (r_pending) begin
                r_processed <= r_processed + 1'b1;
            end
            if (w_is_data) begin
                r_data[r_data_count[DATA_ADDR_BITS-1:0]] <= i_fifo_data;
                r_data_count <= r_data_count + 1'b1;
            end
            if ((w_is_ack && !w_ack_ok) || w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_data       = r_data;
    assign o_data_count = r_data_count;

endmodule

// File: tb/tb_updi_response_handler.sv
module tb_updi_response_handler;

    localparam int MAX = 16;
    localparam int AB  = 4;
    localparam int TO  = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [AB:0]           discard_len = '0;
    logic [AB:0]           rx_len = '0;
    logic                  expect_ack = 1'b0;
    logic                  ready, done, error, ack_received, fifo_rd_en;
    logic [MAX-1:0][7:0]   data;
    logic [AB:0]           data_count;
    logic [7:0]            fifo_data = '0;
    logic                  fifo_empty = 1'b1;

    // RX FIFO model: bytes appended to push_q, head advances on each pop
    logic [7:0] push_q[$];
    int         head = 0;
    int         pops = 0;
    int         underflow = 0;
    logic       flush = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [7:0] m_data[MAX];
    logic [7:0] old_data[MAX];
    int         m_cnt, m_pops, m_lat;
    logic       m_err, m_ack;

    int   last_done_cyc;
    logic last_err;
    int   last_acks;

    always #5 clk = ~clk;

    updi_response_handler #(
        .MAX_DATA_SIZE  (MAX),
        .DATA_ADDR_BITS (AB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .o_ready        (ready),
        .o_done         (done),
        .o_error        (error),
        .o_ack_received (ack_received),
        .i_discard_len  (discard_len),
        .i_rx_len       (rx_len),
        .i_expect_ack   (expect_ack),
        .o_data         (data),
        .o_data_count   (data_count),
        .i_fifo_data    (fifo_data),
        .o_fifo_rd_en   (fifo_rd_en),
        .i_fifo_empty   (fifo_empty)
    );

    always @(posedge clk) begin
        if (flush) begin
            head       <= push_q.size();
            fifo_empty <= 1'b1;
        end else if (fifo_rd_en && (head < push_q.size())) begin
            fifo_data  <= push_q[head];
            head       <= head + 1;
            pops       <= pops + 1;
            fifo_empty <= ((head + 1) >= push_q.size());
        end else begin
            if (fifo_rd_en) underflow <= underflow + 1;
            fifo_empty <= (head >= push_q.size());
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [127:0] pack(input logic [7:0] a[MAX]);
        logic [127:0] r;
        for (int i = 0; i < MAX; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    // Outcome of one transaction from the stream of bytes the FIFO will hold
    task automatic model(input int dl, input int rl, input logic ea, input logic [7:0] b[$]);
        int total;
        for (int i = 0; i < MAX; i++) old_data[i] = m_data[i];
        m_ack = 1'b0; m_err = 1'b0; m_cnt = 0; m_pops = 0; m_lat = 1;
        if (rl > MAX) begin
            m_err = 1'b1;
        end else begin
            total  = dl + rl + (ea ? 1 : 0);
            m_pops = total;
            m_cnt  = rl;
            m_lat  = (total == 0) ? 1 : total + 2;
            for (int i = 0; i < rl; i++) m_data[i] = b[dl + i];
            if (ea) begin
                m_ack = (b[total-1] == 8'h40);
                m_err = !m_ack;
            end
        end
    endtask

    // gap==0: bytes preloaded before start; gap>0: one byte every gap cycles
    // after pre_idle idle cycles.
    task automatic run_txn(input int dl, input int rl, input logic ea, input logic [7:0] b[$],
                           input int gap, input int pre_idle, input string nm);
        int           n, idx, p0, ack_cyc;
        logic         seen, idle_bad;
        logic [127:0] expd;
        model(dl, rl, ea, b);
        p0 = pops; idx = 0; seen = 1'b0; idle_bad = 1'b0;
        last_acks = 0; ack_cyc = -1; last_done_cyc = -1; last_err = 1'b0;
        @(negedge clk);
        if (gap == 0) foreach (b[i]) push_q.push_back(b[i]);
        discard_len = dl[AB:0]; rx_len = rl[AB:0]; expect_ack = ea; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!seen && n <= 400) begin
            if (gap > 0 && idx < b.size() && n > pre_idle && ((n - pre_idle - 1) % gap == 0)) begin
                push_q.push_back(b[idx]);
                idx++;
            end
            if (n <= pre_idle && (fifo_rd_en || ready)) idle_bad = 1'b1;
            for (int i = 0; i < MAX; i++) expd[i*8 +: 8] = (i < int'(data_count)) ? m_data[i] : old_data[i];
            check({nm, "_data_cycle"}, data, expd);
            check({nm, "_count_bound"}, 128'(int'(data_count) <= m_cnt), 128'(1));
            if (ack_received) begin last_acks++; ack_cyc = n; end
            if (done) begin
                seen = 1'b1; last_done_cyc = n; last_err = error;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check({nm, "_done_seen"}, 128'(seen), 128'(1));
        if (gap == 0) check({nm, "_latency"}, 128'(last_done_cyc), 128'(m_lat));
        if (pre_idle > 0) check({nm, "_idle_wait"}, 128'(idle_bad), 128'(0));
        check({nm, "_error"}, 128'(last_err), 128'(m_err));
        check({nm, "_ack_pulses"}, 128'(last_acks), 128'(m_ack));
        if (m_ack) check({nm, "_ack_timing"}, 128'(ack_cyc), 128'(last_done_cyc - 1));
        check({nm, "_data_count"}, 128'(data_count), 128'(m_cnt));
        check({nm, "_data"}, data, pack(m_data));
        check({nm, "_pops"}, 128'(pops - p0), 128'(m_pops));
        check({nm, "_underflow"}, 128'(underflow), 128'(0));
        if (rl <= MAX) check({nm, "_fifo_drained"}, 128'(head), 128'(push_q.size()));
        @(negedge clk);
        check({nm, "_ready_after"}, 128'({ready, done}), 128'(2'b10));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        int         n, dl, rl;
        logic       ea, seen;
        logic [7:0] bq[$];

        for (int i = 0; i < MAX; i++) m_data[i] = 8'h00;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_held_outputs", 128'({ready, done, error, ack_received, fifo_rd_en}), 128'(5'b10000));
        rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", 128'({ready, done, error, ack_received, fifo_rd_en}), 128'(5'b10000));
        check("rst_data_count", 128'(data_count), 128'(0));
        check("rst_data", data, 128'(0));

        // 1: two echo bytes dropped, 16 payload bytes captured
        bq = {8'h55, 8'hE5};
        for (int i = 0; i < 16; i++) bq.push_back(8'(i));
        run_txn(2, 16, 1'b0, bq, 0, 0, "t1");
        check("t1_literal_data", data, 128'h0F0E0D0C0B0A09080706050403020100);
        check("t1_literal_latency", 128'(last_done_cyc), 128'(20));

        // 2: echo only, good ACK
        bq = {8'h55, 8'h45, 8'h12, 8'h34, 8'h40};
        run_txn(4, 0, 1'b1, bq, 0, 0, "t2");
        check("t2_literal_ack", 128'({last_acks[1:0], last_err}), 128'(3'b010));
        check("t2_literal_latency", 128'(last_done_cyc), 128'(7));

        // 3: bad ACK byte
        bq = {8'h55, 8'h45, 8'h12, 8'h34, 8'h41};
        run_txn(4, 0, 1'b1, bq, 0, 0, "t3");
        check("t3_literal_err", 128'({last_acks[1:0], last_err}), 128'(3'b001));

        // 4: start on an empty FIFO, bytes trickle in
        bq = {8'hAA, 8'hBB, 8'hCC};
        run_txn(1, 2, 1'b0, bq, 3, 10, "t4");
        check("t4_literal_data", 128'({data[1], data[0]}), 128'(16'hCCBB));

        // randomized transactions
        for (int t = 0; t < 24; t++) begin
            dl = $urandom_range(0, 3);
            rl = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
            ea = 1'($urandom_range(0, 1));
            bq = {};
            if (rl <= MAX) begin
                for (int i = 0; i < dl + rl; i++) bq.push_back(8'($urandom_range(0, 255)));
                if (ea) bq.push_back(($urandom_range(0, 1) == 1) ? 8'h40 : 8'($urandom_range(0, 255)));
            end
            run_txn(dl, rl, ea, bq, ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3), 0,
                    $sformatf("rnd%0d", t));
        end

        // 5: async reset in the middle of READ, then oversized request
        @(negedge clk);
        push_q.push_back(8'h77);
        discard_len = '0; rx_len = 5'd3; expect_ack = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (data_count != 5'd1 && n < 20) begin @(negedge clk); n++; end
        check("t5_first_byte", 128'(data_count), 128'(1));
        check("t5_midread_busy", 128'(ready), 128'(0));
        #2 rst = 1'b1;
        #1;
        check("t5_rst_ready_rd", 128'({ready, fifo_rd_en}), 128'(2'b10));
        check("t5_rst_count", 128'(data_count), 128'(0));
        check("t5_rst_data", data, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < MAX; i++) m_data[i] = 8'h00;
        push_q.push_back(8'h99);
        bq = {};
        run_txn(0, 17, 1'b0, bq, 0, 0, "t5_badlen");
        check("t5_literal_err", 128'({last_err, last_done_cyc[3:0]}), 128'(5'b10001));

        // 6: starved READ
        @(negedge clk);
        discard_len = '0; rx_len = 5'd1; expect_ack = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef UPDI_RESPONSE_TIMEOUT_EN
        n = 1; seen = 1'b0;
        while (!seen && n <= 50) begin
            if (done) begin
                seen = 1'b1;
                check("t6_timeout_err", 128'(error), 128'(1));
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check("t6_timeout_cycle", 128'(n), 128'(TO + 1));
        check("t6_timeout_count", 128'(data_count), 128'(0));
        @(negedge clk);
        check("t6_ready_after", 128'(ready), 128'(1));
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done || fifo_rd_en || ready) seen = 1'b1;
            @(negedge clk);
        end
        check("t6_still_waiting", 128'(seen), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_recover_ready", 128'(ready), 128'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
